hci_mem_bank_adapter: RTL and testbench

HCI_MEM_BANK_ADAPTER -- requirements
Module: hci_mem_bank_adapter

---
 rtl/hci_mem_bank_adapter.sv | 128 ++++++++++++
 tb/tb_hci_mem_bank_adapter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hci_mem_bank_adapter.sv
// -----------------------------------------------------------------------------
// hci_mem_bank_adapter
//
// Adapts one HCI interconnect slave port to a single-port SRAM bank. Normal
// reads and writes pass straight through to the SRAM. Every granted request
// gets a response one cycle later.
//
// Optional test-and-set (macro HCI_BANK_TEST_SET_EN): a read with ts_set_i=1
// returns the old word and then, in a second cycle (state TS_WR), writes all
// ones to the same address. No new request is granted during that cycle.
// Without the macro, ts_set_i is ignored and the bank is a plain adapter.
//
// Ports
//   clk_i, rst_ni         clock, async active-low reset
//   req_i/add_i/wen_i/    interconnect request (wen_i: 1 = read, 0 = write)
//   data_i/be_i/id_i/
//   ts_set_i
//   gnt_o                 request accepted this cycle
//   r_valid_o/r_data_o/   response, one cycle after grant
//   r_id_o
//   sram_*_o              SRAM port (sram_we_o: 1 = write)
//   sram_rdata_i          SRAM read data, one cycle after a read access
// -----------------------------------------------------------------------------
module hci_mem_bank_adapter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [AW-1:0]     add_i,
    input  logic              wen_i,
    input  logic [DW-1:0]     data_i,
    input  logic [DW/8-1:0]   be_i,
    input  logic [IW-1:0]     id_i,
    input  logic              ts_set_i,
    output logic              gnt_o,
    output logic              r_valid_o,
    output logic [DW-1:0]     r_data_o,
    output logic [IW-1:0]     r_id_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [AW-1:0]     sram_addr_o,
    output logic [DW-1:0]     sram_wdata_o,
    output logic [DW/8-1:0]   sram_be_o,
    input  logic [DW-1:0]     sram_rdata_i
);

    logic          in_ts;     // current cycle is the all-ones write of a test-and-set
    logic [AW-1:0] ts_addr;   // address of that write
    logic          gnt_int;   // grant, not yet gated by reset

`ifdef HCI_BANK_TEST_SET_EN
    typedef enum logic {IDLE = 1'b0, TS_WR = 1'b1} state_e;

    state_e        state_q;
    logic [AW-1:0] ts_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ts_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ts_set_i only matters on a read; a write with it set is plain
                    if (req_i && wen_i && ts_set_i) begin
                        state_q   <= TS_WR;
                        ts_addr_q <= add_i;
                    end
                end
                TS_WR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ts   = (state_q == TS_WR);
    assign ts_addr = ts_addr_q;
`else
    logic unused_ts;
    assign unused_ts = ts_set_i;
    assign in_ts     = 1'b0;
    assign ts_addr   = '0;
`endif

    assign gnt_int = req_i & ~in_ts;

    // Reset gates the externally visible grant and chip enable so an
    // in-flight test-and-set write is cut off the moment reset asserts.
    assign gnt_o        = gnt_int & rst_ni;
    assign sram_ce_o    = (in_ts | req_i) & rst_ni;
    assign sram_we_o    = in_ts | ~wen_i;
    assign sram_addr_o  = in_ts ? ts_addr : add_i;
    assign sram_wdata_o = in_ts ? {DW{1'b1}} : data_i;
    assign sram_be_o    = in_ts ? {(DW/8){1'b1}} : be_i;

    // Response pipeline
    logic          r_valid_q, r_valid_d;
    logic          r_rd_q, r_rd_d;
    logic [IW-1:0] r_id_q, r_id_d;

    always_comb begin
        r_valid_d = gnt_int;
        r_rd_d    = gnt_int & wen_i;
        r_id_d    = gnt_int ? id_i : r_id_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_rd_q    <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_rd_q    <= r_rd_d;
            r_id_q    <= r_id_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    // Reads return the SRAM output; writes and idle cycles return zero.
    // In TS_WR the SRAM output still holds the pre-write word.
    assign r_data_o  = (r_valid_q && r_rd_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_hci_mem_bank_adapter.sv
module tb_hci_mem_bank_adapter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 20;
    localparam int BW = DW/8;
`ifdef HCI_BANK_TEST_SET_EN
    localparam bit TSEN = 1'b1;
`else
    localparam bit TSEN = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_i = 1'b0;
    logic [AW-1:0]   add_i = '0;
    logic            wen_i = 1'b1;
    logic [DW-1:0]   data_i = '0;
    logic [BW-1:0]   be_i = '0;
    logic [IW-1:0]   id_i = '0;
    logic            ts_set_i = 1'b0;
    logic            gnt_o, r_valid_o, sram_ce_o, sram_we_o;
    logic [DW-1:0]   r_data_o, sram_wdata_o;
    logic [IW-1:0]   r_id_o;
    logic [AW-1:0]   sram_addr_o;
    logic [BW-1:0]   sram_be_o;
    logic [DW-1:0]   sram_rdata_i = '0;

    hci_mem_bank_adapter #(.AW(AW), .DW(DW), .IW(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i),
        .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
        .ts_set_i(ts_set_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_data_o(r_data_o), .r_id_o(r_id_o), .sram_ce_o(sram_ce_o),
        .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
        .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Simple SRAM environment
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk_i) begin
        if (sram_ce_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: word memory plus "next cycle is the all-ones write" flag
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ts_block = 1'b0;
    logic [AW-1:0] ts_addr_m = '0;

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } resp_t;
    resp_t q[$];
    bit mon_en = 1'b0;

    // Monitor: every cycle either a response is due (and must appear) or none may
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                resp_t e;
                e = q.pop_front();
                chk("r_valid", r_valid_o, 1);
                chk("r_id", r_id_o, e.id);
                chk("r_data", r_data_o, e.data);
            end else begin
                chk("r_valid_idle", r_valid_o, 0);
                chk("r_data_idle", r_data_o, 0);
            end
        end
    end

    // One cycle with the currently driven inputs; entered just after a posedge
    task automatic step(output bit granted);
        bit exp_gnt, nxt_block;
        @(negedge clk_i);
        exp_gnt = req_i && !ts_block;
        chk("gnt", gnt_o, exp_gnt);
        if (ts_block) begin
            chk("ts_ce", sram_ce_o, 1);
            chk("ts_we", sram_we_o, 1);
            chk("ts_addr", sram_addr_o, ts_addr_m);
            chk("ts_wdata", sram_wdata_o, {DW{1'b1}});
            chk("ts_be", sram_be_o, {BW{1'b1}});
        end else if (req_i) begin
            chk("ce", sram_ce_o, 1);
            chk("we", sram_we_o, !wen_i);
            chk("addr", sram_addr_o, add_i);
            chk("wdata", sram_wdata_o, data_i);
            chk("be", sram_be_o, be_i);
        end else begin
            chk("ce_idle", sram_ce_o, 0);
        end
        nxt_block = 1'b0;
        if (exp_gnt) begin
            if (wen_i) begin
                q.push_back('{cyc + 1, id_i, ref_mem[add_i]});
                if (TSEN && ts_set_i) begin
                    nxt_block = 1'b1;
                    ts_addr_m = add_i;
                end
            end else begin
                for (int b = 0; b < BW; b++)
                    if (be_i[b]) ref_mem[add_i][8*b +: 8] = data_i[8*b +: 8];
                q.push_back('{cyc + 1, id_i, '0});
            end
        end
        if (ts_block) ref_mem[ts_addr_m] = '1;
        ts_block = nxt_block;
        granted = exp_gnt;
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and hold it until granted (bounded)
    task automatic issue(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be, input logic [IW-1:0] id, input logic ts,
                         output int gcyc);
        bit g;
        int tries;
        req_i = 1'b1; wen_i = wen; add_i = a; data_i = d; be_i = be; id_i = id; ts_set_i = ts;
        g = 1'b0; tries = 0; gcyc = -1;
        while (!g && tries < 3) begin
            gcyc = cyc;
            step(g);
            tries++;
        end
        if (!g) begin
            n_chk++;
            $display("FAIL grant_timeout: got no grant expected grant within 3 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit g;
        req_i = 1'b0; ts_set_i = 1'b0;
        for (int i = 0; i < n; i++) step(g);
    endtask

    initial begin
        int g0, g1, g2, gd;
        for (int i = 0; i < (1<<AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        // Reset state, with a request pending
        req_i = 1'b1; wen_i = 1'b1;
        #2;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_ce", sram_ce_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_id", r_id_o, 0);
        chk("rst_r_data", r_data_o, 0);
        req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Directed write/read
        issue(1'b0, 12'h010, 32'hDEADBEEF, 4'hF, 20'd3, 1'b0, g0);
        issue(1'b1, 12'h010, 32'h0, 4'hF, 20'd4, 1'b0, g0);
        idle(1);
        // Test-and-set at 0x020 then read back
        issue(1'b1, 12'h020, 32'h0, 4'hF, 20'd5, 1'b1, g0);
        issue(1'b1, 12'h020, 32'h0, 4'hF, 20'd6, 1'b0, g0);
        idle(2);
        // Held request stream: two test-and-sets then a write
        issue(1'b1, 12'h040, 32'h0, 4'hF, 20'd7, 1'b1, g0);
        issue(1'b1, 12'h041, 32'h0, 4'hF, 20'd8, 1'b1, g1);
        issue(1'b0, 12'h042, 32'h12345678, 4'h5, 20'd9, 1'b1, g2);
        gd = TSEN ? 2 : 1;
        chk("grant_gap1", g1 - g0, gd);
        chk("grant_gap2", g2 - g1, gd);
        idle(1);

        // Randomized traffic over a small address window
        for (int n = 0; n < 1500; n++) begin
            issue(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
                  4'($urandom), 20'($urandom), 1'($urandom_range(0, 2) == 0), g0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        chk("drain", q.size(), 0);

        // Reset in the cycle after a (test-and-set) read grant
        ref_mem[12'h030] = 32'hA5A5_0F0F;
        sram_mem[12'h030] = 32'hA5A5_0F0F;
        issue(1'b1, 12'h030, 32'h0, 4'hF, 20'd11, 1'b1, g0);
        mon_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_abort_ce", sram_ce_o, 0);
        chk("rst_abort_r_valid", r_valid_o, 0);
        chk("rst_abort_gnt", gnt_o, 0);
        q.delete();
        ts_block = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        idle(3);
        // The aborted all-ones write must not have landed
        issue(1'b1, 12'h030, 32'h0, 4'hF, 20'd12, 1'b0, g0);
        idle(3);
        chk("drain_end", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
